// File: rtl/serial_bus_arbiter.sv
// Fixed-priority arbiter for a shared serial bus: decodes per-master request
// frames, runs the grant/ack/release handshake and drives one-hot bus selects.

module serial_bus_arbiter_rx #(
    parameter int SLAVE_ID_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      en,
    input  logic                      bitIn,
    output logic                      frameOk,
    output logic [SLAVE_ID_WIDTH-1:0] frameId
);
    localparam int FRAME = 3 + SLAVE_ID_WIDTH;
    localparam int CNT_W = $clog2(FRAME);

    logic             busy;
    logic [CNT_W-1:0] bitCnt;
    logic [FRAME-2:0] shiftReg;
    logic [FRAME-1:0] frame;

    // frame is the full word as it will look once the current bit is shifted in
    assign frame   = {shiftReg, bitIn};
    assign frameOk = en && busy && (bitCnt == CNT_W'(FRAME - 1)) && (frame[FRAME-1 -: 3] == 3'b111);
    assign frameId = frame[SLAVE_ID_WIDTH-1:0];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busy     <= 1'b0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else if (!en) begin
            busy     <= 1'b0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else if (!busy) begin
            if (bitIn) begin
                busy     <= 1'b1;
                bitCnt   <= CNT_W'(1);
                shiftReg <= {{(FRAME-2){1'b0}}, 1'b1};
            end
        end else begin
            shiftReg <= frame[FRAME-2:0];
            if (bitCnt == CNT_W'(FRAME - 1)) begin
                busy   <= 1'b0;
                bitCnt <= '0;
            end else begin
                bitCnt <= bitCnt + CNT_W'(1);
            end
        end
    end
endmodule

module serial_bus_arbiter #(
    parameter  int NUM_MASTERS    = 2,
    parameter  int SLAVE_ID_WIDTH = 2,
    parameter  int ACK_TIMEOUT    = 8,
    parameter  int PREEMPT_EN     = 1,
    localparam int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [NUM_MASTERS-1:0]    arbSend,
    output logic [NUM_MASTERS-1:0]    arbCont,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic                      grantValid,
    output logic [IDX_W-1:0]          grantIdx,
    output logic [SLAVE_ID_WIDTH-1:0] grantSlaveId
);
    localparam int CNT_W = (ACK_TIMEOUT > 4) ? $clog2(ACK_TIMEOUT) : 2;

    typedef enum logic [2:0] {IDLE, GRANT, ACK_WAIT, BUSY, PREEMPT, RELEASE_WAIT} state_t;

    state_t                                        state, stateNext;
    logic   [IDX_W-1:0]                            owner, ownerNext, winIdx;
    logic   [CNT_W-1:0]                            cnt, cntNext;
    logic   [1:0]                                  ackRun, ackRunNext;
    logic   [NUM_MASTERS-1:0]                      pending, rxOk, rxEn, clrMask;
    logic   [NUM_MASTERS-1:0][SLAVE_ID_WIDTH-1:0]  ids, rxId;
    logic                                          anyPend, higherPend, ownSend;

    // The owner's line carries ack/release, so its frame decoder is parked.
    for (genvar m = 0; m < NUM_MASTERS; m++) begin : gRx
        assign rxEn[m] = (state == IDLE) || (owner != IDX_W'(m));
        serial_bus_arbiter_rx #(.SLAVE_ID_WIDTH(SLAVE_ID_WIDTH)) uRx (
            .clk     (clk),
            .rstN    (rstN),
            .en      (rxEn[m]),
            .bitIn   (arbSend[m]),
            .frameOk (rxOk[m]),
            .frameId (rxId[m])
        );
    end

    always_comb begin
        winIdx     = '0;
        anyPend    = |pending;
        higherPend = 1'b0;
        for (int m = NUM_MASTERS - 1; m >= 0; m--)
            if (pending[m]) winIdx = IDX_W'(m);
        for (int m = 0; m < NUM_MASTERS; m++)
            if (m < int'(owner) && pending[m]) higherPend = 1'b1;
    end

    assign ownSend = arbSend[owner];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= IDLE;
            owner   <= '0;
            cnt     <= '0;
            ackRun  <= '0;
            pending <= '0;
            ids     <= '0;
        end else begin
            state   <= stateNext;
            owner   <= ownerNext;
            cnt     <= cntNext;
            ackRun  <= ackRunNext;
            pending <= (pending & ~clrMask) | rxOk;
            for (int m = 0; m < NUM_MASTERS; m++)
                if (rxOk[m]) ids[m] <= rxId[m];
        end
    end

    always_comb begin
        stateNext  = state;
        ownerNext  = owner;
        cntNext    = cnt;
        ackRunNext = ackRun;
        clrMask    = '0;
        case (state)
            IDLE: if (anyPend) begin
                ownerNext       = winIdx;
                clrMask[winIdx] = 1'b1;
                cntNext         = '0;
                stateNext       = GRANT;
            end
            GRANT: if (cnt == CNT_W'(2)) begin
                cntNext    = '0;
                ackRunNext = '0;
                stateNext  = ACK_WAIT;
            end else begin
                cntNext = cnt + CNT_W'(1);
            end
            ACK_WAIT: begin
                // an ack completing on the last allowed cycle still wins
                cntNext    = cnt + CNT_W'(1);
                ackRunNext = ownSend ? ackRun + 2'd1 : 2'd0;
                if (ownSend && ackRun == 2'd2)
                    stateNext = BUSY;
                else if (cnt == CNT_W'(ACK_TIMEOUT - 1))
                    stateNext = IDLE;
            end
            BUSY: if (ownSend) begin
                stateNext = IDLE;
            end else if (PREEMPT_EN != 0 && higherPend) begin
                cntNext   = '0;
                stateNext = PREEMPT;
            end
            PREEMPT: if (cnt == CNT_W'(2)) begin
                stateNext = RELEASE_WAIT;
            end else begin
                cntNext = cnt + CNT_W'(1);
            end
            RELEASE_WAIT: if (ownSend) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        arbCont      = '0;
        grant        = '0;
        grantValid   = 1'b0;
        grantIdx     = '0;
        grantSlaveId = '0;
        if (state == GRANT || state == PREEMPT) arbCont[owner] = 1'b1;
        if (state == BUSY || state == PREEMPT || state == RELEASE_WAIT) begin
            grant[owner] = 1'b1;
            grantValid   = 1'b1;
            grantIdx     = owner;
            grantSlaveId = ids[owner];
        end
    end
endmodule
